// File: rtl/fp_divider_pkg.sv
// Shared definitions for the single-precision FP divider.
// Field widths default to IEEE-754 binary32; FSM encodings live here too.
package fp_divider_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

endpackage

// File: rtl/fp_divider_mant_div_iter.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first.
// Free-runs after load until QBITS bits are produced, then holds q.
module mant_div_iter #(
    parameter int MW    = 24,
    parameter int QBITS = 26,
    parameter int CW    = $clog2(QBITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [MW-1:0]    dividend,
    input  logic [MW-1:0]    divisor,
    output logic [QBITS-1:0] q,
    output logic             rem_nz,
    output logic [CW-1:0]    cnt
);

    logic [MW:0]   rem;
    logic [MW-1:0] dvs;
    logic [MW+1:0] trial;
    logic          ge;
    logic [MW-1:0] kept;

    always_comb begin
        trial = {1'b0, rem} - {2'b00, dvs};
        ge    = ~trial[MW+1];
        kept  = ge ? trial[MW-1:0] : rem[MW-1:0];
    end

    assign rem_nz = |rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            dvs <= '0;
            q   <= '0;
            cnt <= CW'(QBITS);
        end else if (load) begin
            rem <= {1'b0, dividend};
            dvs <= divisor;
            q   <= '0;
            cnt <= '0;
        end else if (cnt != CW'(QBITS)) begin
            q   <= {q[QBITS-2:0], ge};
            rem <= {kept, 1'b0};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider with start/busy/done handshake.
// Define FPD_ROUND_EN for round-to-nearest-even; default truncates.
module fp_divider
    import fp_divider_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   div_by_zero
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int MW    = MAN_W + 1;
    localparam int QBITS = MAN_W + 3;
    localparam int EW    = EXP_W + 2;
    localparam int CW    = $clog2(QBITS + 1);

    localparam logic [EW-1:0]        BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic [EXP_W-1:0]     E_ONES = '1;
    localparam logic [W-2:0]         INF_M  = {E_ONES, {MAN_W{1'b0}}};
    localparam logic [W-1:0]         QNAN   =
        {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FPD_ROUND_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic [1:0]             state;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_r;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             s;
    fp_class_t        ca, cb;

    logic             spec_hit, spec_dbz;
    logic [W-1:0]     spec_res;

    logic             load;
    logic [QBITS-1:0] q;
    logic             rem_nz;
    logic [CW-1:0]    cnt;

    logic [MAN_W-1:0]     man_n, man_f;
    logic [MAN_W:0]       man_inc;
    logic                 guard, sticky, round_up;
    logic signed [EW-1:0] exp_n, exp_f;
    logic [W-1:0]         norm_res;

    always_comb begin
        a_exp   = a[W-2:MAN_W];
        b_exp   = b[W-2:MAN_W];
        a_man   = a[MAN_W-1:0];
        b_man   = b[MAN_W-1:0];
        s       = a[W-1] ^ b[W-1];
        ca.nan  = (&a_exp) & (|a_man);
        ca.inf  = (&a_exp) & ~(|a_man);
        ca.zero = ~(|a_exp) & ~(|a_man);
        cb.nan  = (&b_exp) & (|b_man);
        cb.inf  = (&b_exp) & ~(|b_man);
        cb.zero = ~(|b_exp) & ~(|b_man);
    end

    // Priority order matters: NaN-producing cases win over inf and zero.
    always_comb begin
        spec_hit = 1'b1;
        spec_dbz = 1'b0;
        spec_res = '0;
        if (ca.nan | cb.nan | (ca.zero & cb.zero) | (ca.inf & cb.inf)) begin
            spec_res = QNAN;
        end else if (ca.inf) begin
            spec_res = {s, INF_M};
        end else if (cb.zero) begin
            spec_res = {s, INF_M};
            spec_dbz = 1'b1;
        end else if (ca.zero | cb.inf) begin
            spec_res = {s, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    assign load = (state == ST_IDLE) & start & ~spec_hit;

    mant_div_iter #(
        .MW    (MW),
        .QBITS (QBITS),
        .CW    (CW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dividend ({|a_exp, a_man}),
        .divisor  ({|b_exp, b_man}),
        .q        (q),
        .rem_nz   (rem_nz),
        .cnt      (cnt)
    );

    // Quotient lies in (0.5, 2): at most one left shift to normalise.
    always_comb begin
        man_n  = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        exp_n  = exp_r;
        if (q[QBITS-1]) begin
            man_n  = q[QBITS-2:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            exp_n  = exp_r;
        end else begin
            man_n  = q[QBITS-3:1];
            guard  = q[0];
            sticky = rem_nz;
            exp_n  = exp_r - ONE_S;
        end
        round_up = RNE & guard & (sticky | man_n[0]);
        man_inc  = {1'b0, man_n} + {{MAN_W{1'b0}}, round_up};
        man_f    = man_inc[MAN_W-1:0];
        exp_f    = exp_n + {{(EW-1){1'b0}}, man_inc[MAN_W]};
        if (exp_f >= EMAX_S) begin
            norm_res = {sign_r, INF_M};
        end else if (exp_f <= ZERO_S) begin
            norm_res = {sign_r, {(W-1){1'b0}}};
        end else begin
            norm_res = {sign_r, exp_f[EXP_W-1:0], man_f};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign_r <= s;
                        exp_r  <= {2'b00, a_exp} - {2'b00, b_exp} + BIAS;
                        if (spec_hit) begin
                            done        <= 1'b1;
                            result      <= spec_res;
                            div_by_zero <= spec_dbz;
                        end else begin
                            state <= ST_DIV;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (cnt == CW'(QBITS - 1)) state <= ST_NORM;
                end
                ST_NORM: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    result      <= norm_res;
                    div_by_zero <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: results, latency, busy window,
// special cases, ignored mid-op start and reset abort.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    fp_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

`ifdef FPD_ROUND_EN
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Start in the current cycle (cycle 0), watch until done or budget.
    task automatic run_vec(input logic [31:0] va, input logic [31:0] vb,
                           output logic [31:0] r, output logic dz,
                           output int lat, output int bcnt);
        start = 1'b1;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h12345678;
        lat   = -1;
        bcnt  = 0;
        r     = 'x;
        dz    = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                r   = result;
                dz  = div_by_zero;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        dz;
        int          lat, bcnt, ndone, dcyc;
        logic [31:0] dres;

        vecs[0]  = '{32'h41000000, 32'h40000000, 32'h40800000, 1'b0, 28};
        vecs[1]  = '{32'h3F800000, 32'h40400000, THIRD,        1'b0, 28};
        vecs[2]  = '{32'h40C80000, 32'hC0200000, 32'hC0200000, 1'b0, 28};
        vecs[3]  = '{32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1};
        vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1};
        vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28};
        vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 28};
        vecs[8]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1};
        vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1};
        vecs[10] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1};
        vecs[11] = '{32'h40400000, 32'h7F800000, 32'h00000000, 1'b0, 1};
        vecs[12] = '{32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0, 28};
        vecs[13] = '{32'hC0A00000, 32'h00000000, 32'hFF800000, 1'b1, 1};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy",   {31'b0, busy},        32'd0);
        chk("rst_done",   {31'b0, done},        32'd0);
        chk("rst_result", result,               32'd0);
        chk("rst_dbz",    {31'b0, div_by_zero}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i].a, vecs[i].b, r, dz, lat, bcnt);
            chk($sformatf("v%0d_result", i), r, vecs[i].res);
            chk($sformatf("v%0d_dbz", i), {31'b0, dz}, {31'b0, vecs[i].dbz});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bcnt,
                (vecs[i].lat == 28) ? 27 : 0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
            chk($sformatf("v%0d_result_held", i), result, vecs[i].res);
            tick();
        end

        // Second start in the middle of an operation must be ignored.
        start = 1'b1;
        a     = 32'h41000000;
        b     = 32'h40000000;
        tick();
        start = 1'b0;
        ndone = 0;
        dcyc  = -1;
        dres  = '0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin
                start = 1'b1;
                a     = 32'h3F800000;
                b     = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = c;
                    dres = result;
                end
            end
            tick();
        end
        chk("hs_done_count", ndone, 1);
        chk("hs_done_cycle", dcyc, 28);
        chk("hs_result", dres, 32'h40800000);

        // Reset mid-operation aborts without a done.
        start = 1'b1;
        a     = 32'h40C80000;
        b     = 32'hC0200000;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy_after", {31'b0, busy}, 32'd0);
        chk("abort_done_after", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) ndone++;
            tick();
        end
        chk("abort_no_activity", ndone, 0);

        run_vec(32'h41000000, 32'h40000000, r, dz, lat, bcnt);
        chk("restart_result", r, 32'h40800000);
        chk("restart_latency", lat, 28);
        chk("restart_busy_cycles", bcnt, 27);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
